// File: rtl/sequence_check.sv
`timescale 1ns/1ps
// Checks a player-entered button sequence against a pattern held in external memory.
// It compares one press per entry and reports pass, fail or timeout with the index of the offending entry.
module sequence_check #(
  parameter int BTN_W       = 3,
  parameter int MAX_LEN     = 16,
  parameter int LEN_W       = $clog2(MAX_LEN + 1),
  parameter int IDX_W       = $clog2(MAX_LEN),
  parameter int TIMEOUT_CYC = 1000,
  parameter int TO_W        = $clog2(TIMEOUT_CYC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] len,
  input  logic [BTN_W-1:0] click,
  input  logic [BTN_W-1:0] seq_val,
  output logic [IDX_W-1:0] seq_addr,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [IDX_W-1:0] err_idx
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DONE} state_t;

  state_t           state, state_next;
  logic [LEN_W-1:0] len_q, len_next;
  logic [IDX_W-1:0] idx, idx_next;
  logic [TO_W-1:0]  timer, timer_next;
  logic [BTN_W-1:0] expected, expected_next;
  logic [BTN_W-1:0] click_prev;
  logic             pass_next, fail_next, timeout_next;
  logic [IDX_W-1:0] err_next;
  logic             press, len_ok, last_entry, expired;

  // A press is a release-to-nonzero edge, so a held or switched button never counts twice.
  assign press      = (click_prev == '0) && (click != '0);
  assign len_ok     = (len != '0) && (len <= LEN_W'(MAX_LEN));
  assign last_entry = (LEN_W'(idx) == (len_q - LEN_W'(1)));
  assign expired    = (timer == TO_W'(TIMEOUT_CYC - 1));

  assign seq_addr = idx;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      len_q      <= '0;
      idx        <= '0;
      timer      <= '0;
      expected   <= '0;
      click_prev <= '0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      timeout    <= 1'b0;
      err_idx    <= '0;
    end else begin
      state      <= state_next;
      len_q      <= len_next;
      idx        <= idx_next;
      timer      <= timer_next;
      expected   <= expected_next;
      click_prev <= click;
      pass       <= pass_next;
      fail       <= fail_next;
      timeout    <= timeout_next;
      err_idx    <= err_next;
    end
  end

  always_comb begin
    state_next    = state;
    len_next      = len_q;
    idx_next      = idx;
    timer_next    = timer;
    expected_next = expected;
    pass_next     = pass;
    fail_next     = fail;
    timeout_next  = timeout;
    err_next      = err_idx;

    case (state)
      IDLE: begin
        if (start) begin
          pass_next    = 1'b0;
          fail_next    = 1'b0;
          timeout_next = 1'b0;
          err_next     = '0;
          idx_next     = '0;
          if (len_ok) begin
            len_next   = len;
            state_next = FETCH;
          end else begin
            fail_next  = 1'b1;
            state_next = DONE;
          end
        end
      end
      FETCH: begin
        if (abort) begin
          state_next = IDLE;
        end else begin
          expected_next = seq_val;
          timer_next    = '0;
          state_next    = WAIT;
        end
      end
      WAIT: begin
        // Abort beats a press, and a press beats expiry on the same cycle.
        if (abort) begin
          state_next = IDLE;
        end else if (press) begin
          if (click == expected) begin
            if (last_entry) begin
              pass_next  = 1'b1;
              state_next = DONE;
            end else begin
              idx_next   = idx + IDX_W'(1);
              state_next = FETCH;
            end
          end else begin
            fail_next  = 1'b1;
            err_next   = idx;
            state_next = DONE;
          end
        end else if (expired) begin
          timeout_next = 1'b1;
          err_next     = idx;
          state_next   = DONE;
        end else begin
          timer_next = timer + TO_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sequence_check.sv
`timescale 1ns/1ps
// Directed and random runs of sequence_check against an event-level model of the player's presses.
// Each run is scheduled cycle by cycle up front, then driven while outputs are compared to the model's predictions.
module tb_sequence_check;

  localparam int BTN_W   = 3;
  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;
  localparam int IDX_W   = 4;
  localparam int TO      = 20;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, abort;
  logic [LEN_W-1:0] len;
  logic [BTN_W-1:0] click, seq_val;
  logic [IDX_W-1:0] seq_addr, err_idx;
  logic             busy, done, pass, fail, timeout;

  sequence_check #(
    .BTN_W(BTN_W), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .IDX_W(IDX_W),
    .TIMEOUT_CYC(TO), .TO_W(5)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .len(len),
    .click(click), .seq_val(seq_val), .seq_addr(seq_addr), .busy(busy),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout), .err_idx(err_idx)
  );

  always #5 clk = ~clk;

  logic [BTN_W-1:0] pattern [MAX_LEN];
  assign seq_val = pattern[seq_addr];

  int checks = 0;
  int errors = 0;

  // One entry per expected press: code pressed, WAIT cycles before it, cycles held.
  int ent_code  [MAX_LEN];
  int ent_delay [MAX_LEN];
  int ent_hold  [MAX_LEN];
  int run_len;

  logic [BTN_W-1:0] click_sched [1024];
  int fetch_cyc [MAX_LEN];
  int press_cyc [MAX_LEN];
  int n_fetch;
  int exp_done_cyc, exp_err;
  bit exp_pass, exp_fail, exp_to;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic set_entry(input int i, input int code, input int delay, input int hold);
    ent_code[i]  = code;
    ent_delay[i] = delay;
    ent_hold[i]  = hold;
  endtask

  task automatic set_pattern3(input int a, input int b, input int c);
    pattern[0] = BTN_W'(a);
    pattern[1] = BTN_W'(b);
    pattern[2] = BTN_W'(c);
  endtask

  // Walks the entries in order, deciding the outcome and the cycle each event lands on.
  task automatic build_expect();
    int t, p;
    for (int c = 0; c < 1024; c++) click_sched[c] = '0;
    n_fetch  = 0;
    exp_pass = 0;
    exp_fail = 0;
    exp_to   = 0;
    exp_err  = 0;
    if (run_len == 0 || run_len > MAX_LEN) begin
      exp_fail     = 1;
      exp_done_cyc = 1;
      return;
    end
    t = 2;
    for (int i = 0; i < run_len; i++) begin
      fetch_cyc[i] = t - 1;
      n_fetch      = i + 1;
      if (ent_delay[i] >= TO) begin
        exp_to       = 1;
        exp_err      = i;
        exp_done_cyc = t + TO;
        break;
      end
      p            = t + ent_delay[i];
      press_cyc[i] = p;
      for (int k = 0; k < ent_hold[i]; k++) click_sched[p + k] = BTN_W'(ent_code[i]);
      if (ent_code[i] != int'(pattern[i])) begin
        exp_fail     = 1;
        exp_err      = i;
        exp_done_cyc = p + 1;
        break;
      end
      if (i == run_len - 1) begin
        exp_pass     = 1;
        exp_done_cyc = p + 1;
        break;
      end
      t = p + 2;
    end
  endtask

  task automatic apply_stimulus(input int abort_cyc, input int extra_start_cyc, input int extra_len);
    int  end_cyc, done_seen, done_at, busy_bad, max_addr, exp_max;
    bit  aborted;
    aborted   = (abort_cyc >= 1) && (abort_cyc < exp_done_cyc);
    end_cyc   = aborted ? abort_cyc : exp_done_cyc;
    done_seen = 0;
    done_at   = -1;
    busy_bad  = 0;
    max_addr  = 0;
    exp_max   = 0;
    for (int k = 0; k < n_fetch; k++) if (fetch_cyc[k] <= end_cyc) exp_max = k;
    for (int c = 0; c <= end_cyc + 2; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_seen++;
        if (done_at < 0) done_at = c;
      end
      if (busy !== ((c >= 1 && c <= end_cyc) ? 1'b1 : 1'b0)) busy_bad++;
      if (busy === 1'b1 && int'(seq_addr) > max_addr) max_addr = int'(seq_addr);
      for (int k = 0; k < n_fetch; k++)
        if (fetch_cyc[k] == c && c <= end_cyc) check_output("fetch_addr", 32'(seq_addr), k);
      if (c == end_cyc + 1) begin
        check_output("pass",    32'(pass),    aborted ? 0 : 32'(exp_pass));
        check_output("fail",    32'(fail),    aborted ? 0 : 32'(exp_fail));
        check_output("timeout", 32'(timeout), aborted ? 0 : 32'(exp_to));
        check_output("err_idx", 32'(err_idx), aborted ? 0 : exp_err);
      end
      click = click_sched[c];
      start = (c == 0) || (c == extra_start_cyc);
      len   = (c == extra_start_cyc) ? LEN_W'(extra_len) : LEN_W'(run_len);
      abort = (c == abort_cyc);
    end
    click = '0;
    start = 1'b0;
    abort = 1'b0;
    check_output("done_count", done_seen, aborted ? 0 : 1);
    if (!aborted) check_output("done_cycle", done_at, exp_done_cyc);
    check_output("busy_window", busy_bad, 0);
    if (n_fetch > 0) check_output("max_addr", max_addr, exp_max);
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    len   = '0;
    click = '0;
    for (int i = 0; i < MAX_LEN; i++) pattern[i] = BTN_W'(1 + (i % 7));
    repeat (3) @(negedge clk);
    check_output("rst_busy",    32'(busy),     0);
    check_output("rst_done",    32'(done),     0);
    check_output("rst_pass",    32'(pass),     0);
    check_output("rst_fail",    32'(fail),     0);
    check_output("rst_timeout", 32'(timeout),  0);
    check_output("rst_err_idx", 32'(err_idx),  0);
    check_output("rst_addr",    32'(seq_addr), 0);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] correct sequence, with an ignored start while busy");
    set_pattern3(1, 4, 2);
    run_len = 3;
    set_entry(0, 1, 1, 1);
    set_entry(1, 4, 1, 1);
    set_entry(2, 2, 1, 1);
    build_expect();
    apply_stimulus(-1, 3, 1);

    $display("[TB] wrong second press");
    set_entry(1, 5, 1, 1);
    build_expect();
    apply_stimulus(-1, -1, 0);

    $display("[TB] timeout and press on the expiry cycle");
    run_len = 2;
    set_entry(0, 1, 25, 1);
    build_expect();
    apply_stimulus(-1, -1, 0);
    set_entry(0, 3, TO - 1, 1);
    build_expect();
    apply_stimulus(-1, -1, 0);

    $display("[TB] hold and repeat");
    pattern[0] = 3'd1;
    pattern[1] = 3'd1;
    set_entry(0, 1, 0, 10);
    set_entry(1, 1, 10, 1);
    build_expect();
    apply_stimulus(-1, -1, 0);
    set_entry(0, 1, 0, 5);
    set_entry(1, 1, 11, 1);
    build_expect();
    for (int c = 7; c <= 12; c++) click_sched[c] = 3'd3;
    apply_stimulus(-1, -1, 0);

    $display("[TB] invalid lengths");
    run_len = 0;
    build_expect();
    apply_stimulus(-1, 1, 3);
    run_len = MAX_LEN + 1;
    build_expect();
    apply_stimulus(-1, -1, 0);

    $display("[TB] abort on the same cycle as a press");
    set_pattern3(1, 4, 2);
    run_len = 3;
    set_entry(0, 1, 1, 1);
    set_entry(1, 5, 2, 1);
    build_expect();
    apply_stimulus(press_cyc[1], -1, 0);

    $display("[TB] reset during FETCH");
    @(negedge clk);
    start = 1'b1;
    len   = LEN_W'(3);
    @(negedge clk);
    start = 1'b0;
    check_output("fetch_busy", 32'(busy), 1);
    rst = 1'b0;
    #1;
    check_output("arst_busy",    32'(busy),     0);
    check_output("arst_done",    32'(done),     0);
    check_output("arst_flags",   32'({pass, fail, timeout}), 0);
    check_output("arst_err_idx", 32'(err_idx),  0);
    check_output("arst_addr",    32'(seq_addr), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    set_entry(1, 4, 1, 1);
    build_expect();
    apply_stimulus(-1, -1, 0);

    $display("[TB] random runs");
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < MAX_LEN; i++) pattern[i] = BTN_W'($urandom_range(1, 7));
      if ($urandom_range(0, 9) == 0) run_len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 31);
      else run_len = $urandom_range(1, MAX_LEN);
      for (int i = 0; i < MAX_LEN; i++) ent_hold[i] = $urandom_range(1, 3);
      for (int i = 0; i < MAX_LEN; i++) begin
        ent_code[i] = ($urandom_range(0, 14) == 0) ? $urandom_range(1, 7) : int'(pattern[i]);
        if ($urandom_range(0, 11) == 0) ent_delay[i] = $urandom_range(TO - 1, TO + 2);
        else ent_delay[i] = ((i == 0) ? 0 : ent_hold[i-1] - 1) + $urandom_range(0, 3);
      end
      build_expect();
      if ($urandom_range(0, 4) == 0 && exp_done_cyc >= 2)
        apply_stimulus($urandom_range(1, exp_done_cyc - 1), -1, 0);
      else
        apply_stimulus(-1, -1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
